// File: rtl/word_announcer.sv
// word_announcer: round sequencer for the FIGHT!/VICTORY!/DEFEAT! banners.
// Counts frame ticks to time the opening and result banners, blinks the
// result banner and gates player input outside of combat.
module word_announcer #(
  parameter int unsigned FIGHT_FRAMES  = 90,
  parameter int unsigned RESULT_FRAMES = 180,
  parameter int unsigned BLINK_BIT     = 3
) (
  input  logic Clk,
  input  logic Reset,
  input  logic frame_clk,
  input  logic round_start,
  input  logic p1_hp_zero,
  input  logic p2_hp_zero,
  output logic fight_active,
  output logic victory_active,
  output logic defeat_active,
  output logic input_enable,
  output logic round_over
);

  localparam logic [8:0] FIGHT_LAST  = 9'(FIGHT_FRAMES - 1);
  localparam logic [8:0] RESULT_LAST = 9'(RESULT_FRAMES - 1);

  typedef enum logic [2:0] {
    IDLE,
    FIGHT,
    COMBAT,
    WIN,
    LOSE
  } state_t;

  state_t     state;
  state_t     state_next;
  logic       frame_q;
  logic       tick;
  logic [8:0] fcnt;
  logic       round_over_q;
  logic       round_over_next;

  // Frame edge detector; resets high so a frame_clk already high at reset
  // release does not produce a spurious tick.
  always_ff @(posedge Clk) begin
    if (!Reset) frame_q <= 1'b1;
    else        frame_q <= frame_clk;
  end

  assign tick = frame_clk & ~frame_q;

  // State register.
  always_ff @(posedge Clk) begin
    if (!Reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state decode and end-of-result-banner detection.
  always_comb begin
    state_next      = state;
    round_over_next = 1'b0;
    case (state)
      IDLE: begin
        if (round_start) state_next = FIGHT;
      end
      FIGHT: begin
        if (tick && (fcnt == FIGHT_LAST)) state_next = COMBAT;
      end
      COMBAT: begin
        // Player 1 takes priority, so a double knock-out is a loss.
        if (p1_hp_zero)      state_next = LOSE;
        else if (p2_hp_zero) state_next = WIN;
      end
      WIN, LOSE: begin
        if (tick && (fcnt == RESULT_LAST)) begin
          state_next      = IDLE;
          round_over_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Frame counter: cleared on every state change (a coinciding tick is
  // dropped), otherwise counts ticks.
  always_ff @(posedge Clk) begin
    if (!Reset)                   fcnt <= '0;
    else if (state_next != state) fcnt <= '0;
    else if (tick)                fcnt <= fcnt + 9'd1;
  end

  // Registered round_over pulse, high for the first IDLE cycle after a result.
  always_ff @(posedge Clk) begin
    if (!Reset) round_over_q <= 1'b0;
    else        round_over_q <= round_over_next;
  end

  // Banner and input-gate decode from state and frame count.
  always_comb begin
    fight_active   = 1'b0;
    victory_active = 1'b0;
    defeat_active  = 1'b0;
    input_enable   = 1'b0;
    case (state)
      FIGHT:   fight_active   = 1'b1;
      COMBAT:  input_enable   = 1'b1;
      WIN:     victory_active = ~fcnt[BLINK_BIT];
      LOSE:    defeat_active  = ~fcnt[BLINK_BIT];
      default: ;
    endcase
  end

  assign round_over = round_over_q;

endmodule

// File: tb/tb_word_announcer.sv
// tb_word_announcer: scoreboard bench for word_announcer with
// FIGHT_FRAMES=3, RESULT_FRAMES=6, BLINK_BIT=1.
module tb_word_announcer;

  logic Clk = 1'b0;
  logic Reset = 1'b0;
  logic frame_clk = 1'b1;
  logic round_start = 1'b0;
  logic p1_hp_zero = 1'b0;
  logic p2_hp_zero = 1'b0;
  logic fight_active, victory_active, defeat_active, input_enable, round_over;

  // Expected output vector: {fight, victory, defeat, input_enable, round_over}
  localparam logic [4:0] E_NONE = 5'b00000;
  localparam logic [4:0] E_FGT  = 5'b10000;
  localparam logic [4:0] E_VIC  = 5'b01000;
  localparam logic [4:0] E_DEF  = 5'b00100;
  localparam logic [4:0] E_IN   = 5'b00010;
  localparam logic [4:0] E_RO   = 5'b00001;

  typedef struct {
    string      name;
    logic [4:0] exp;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  word_announcer #(
    .FIGHT_FRAMES (3),
    .RESULT_FRAMES(6),
    .BLINK_BIT    (1)
  ) dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .frame_clk     (frame_clk),
    .round_start   (round_start),
    .p1_hp_zero    (p1_hp_zero),
    .p2_hp_zero    (p2_hp_zero),
    .fight_active  (fight_active),
    .victory_active(victory_active),
    .defeat_active (defeat_active),
    .input_enable  (input_enable),
    .round_over    (round_over)
  );

  always #5 Clk = ~Clk;

  // Monitor: one expected vector per clock edge, compared on the falling edge.
  always @(negedge Clk) begin
    exp_t       e;
    logic [4:0] act;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      act = {fight_active, victory_active, defeat_active, input_enable, round_over};
      tests++;
      if (act !== e.exp) begin
        fails++;
        $display("FAIL %s @%0t: got %05b expected %05b (fight,vic,def,in,ro)",
                 e.name, $time, act, e.exp);
      end
    end
  end

  // One clock: apply inputs, queue the outputs expected after the next edge.
  task automatic cyc(input string nm, input logic f, input logic rs,
                     input logic p1, input logic p2, input logic rn,
                     input logic [4:0] e);
    exp_t item;
    frame_clk   = f;
    round_start = rs;
    p1_hp_zero  = p1;
    p2_hp_zero  = p2;
    Reset       = rn;
    item.name   = nm;
    item.exp    = e;
    exp_q.push_back(item);
    @(posedge Clk);
    #2;
  endtask

  // Two-clock frame: frame_clk high (tick on this edge), then low.
  task automatic frame(input string nm, input logic rs, input logic p1,
                       input logic p2, input logic [4:0] e);
    cyc(nm, 1'b1, rs, p1, p2, 1'b1, e);
    cyc(nm, 1'b0, rs, p1, p2, 1'b1, e);
  endtask

  // Result-banner visibility with BLINK_BIT=1: visible while fcnt mod 4 < 2.
  function automatic logic [4:0] blink(input int unsigned k, input logic [4:0] word);
    return ((k % 4) < 2) ? word : E_NONE;
  endfunction

  initial begin
    // Reset with frame_clk held high, then release with it still high.
    cyc("reset",      1, 0, 0, 0, 0, E_NONE);
    cyc("reset",      1, 0, 0, 0, 0, E_NONE);
    cyc("rel_hi",     1, 0, 0, 0, 1, E_NONE);
    cyc("rel_hi",     1, 0, 0, 0, 1, E_NONE);
    for (int i = 0; i < 50; i++) frame("idle100", 0, 0, 0, E_NONE);
    // HP flags in IDLE are ignored.
    frame("idle_hp", 0, 1, 1, E_NONE);

    // Round 1: FIGHT lasts 3 ticks, then COMBAT.
    cyc("start",      0, 1, 0, 0, 1, E_FGT);
    cyc("fight0",     0, 0, 0, 0, 1, E_FGT);
    frame("fight_t1", 0, 0, 0, E_FGT);
    frame("fight_t2", 0, 0, 0, E_FGT);
    frame("fight_t3", 0, 0, 0, E_IN);
    frame("combat",   1, 0, 0, E_IN);
    // p2 down: WIN, visible immediately; p1 during WIN is ignored.
    cyc("win_entry",  0, 0, 0, 1, 1, E_VIC);
    for (int unsigned k = 1; k <= 5; k++) frame("win_blink", 0, 1, 0, blink(k, E_VIC));
    cyc("win_end",    1, 0, 0, 0, 1, E_RO);
    // round_start during the round_over cycle is accepted.
    cyc("ro_start",   0, 1, 0, 0, 1, E_FGT);

    // Round 2: round_start and HP flags toggled during FIGHT have no effect.
    frame("fight_ign1", 1, 1, 0, E_FGT);
    frame("fight_ign2", 0, 0, 1, E_FGT);
    frame("fight_ign3", 1, 0, 0, E_IN);
    // Tie: both flags at once resolve to LOSE.
    cyc("tie_entry",  0, 0, 1, 1, 1, E_DEF);
    for (int unsigned k = 1; k <= 5; k++) frame("lose_blink", 0, 1, 1, blink(k, E_DEF));
    cyc("lose_end",   1, 0, 1, 1, 1, E_RO);
    cyc("post_lose",  0, 0, 1, 1, 1, E_NONE);
    cyc("post_lose",  0, 0, 0, 0, 1, E_NONE);

    // Round 3: round_start on a tick edge; that tick is not counted in FIGHT.
    cyc("start_tick", 1, 1, 0, 0, 1, E_FGT);
    cyc("fight0",     0, 0, 0, 0, 1, E_FGT);
    frame("fight_t1", 0, 0, 0, E_FGT);
    frame("fight_t2", 0, 0, 0, E_FGT);
    frame("fight_t3", 0, 0, 0, E_IN);
    // WIN entered on a tick edge; fcnt restarts at 0.
    cyc("win_tick",   1, 0, 0, 1, 1, E_VIC);
    cyc("win_tick",   0, 0, 0, 0, 1, E_VIC);
    for (int unsigned k = 1; k <= 4; k++) frame("win_blink2", 0, 0, 0, blink(k, E_VIC));
    // Reset mid-WIN at fcnt=4: back to IDLE, no round_over pulse.
    cyc("mid_reset",  0, 0, 0, 0, 0, E_NONE);
    for (int i = 0; i < 8; i++) frame("post_reset", 0, 0, 0, E_NONE);
    cyc("restart",    0, 1, 0, 0, 1, E_FGT);
    cyc("restart",    0, 0, 0, 0, 1, E_FGT);

    @(negedge Clk);
    #1;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
